// File: rtl/xor_frame_descrambler.sv
// Receive-side frame descrambler: XORs each byte with a Galois LFSR keystream,
// checks the per-frame XOR checksum and forwards bytes through a registered stage.
module xor_frame_descrambler #(
    parameter logic [7:0]  SEED    = 8'hFF,
    parameter logic [7:0]  POLY    = 8'hB8,
    parameter int unsigned MAX_LEN = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       len_err,
    output logic [7:0] byte_count
);

    localparam logic [7:0] LAST_IDX  = 8'(MAX_LEN - 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] count_q, count_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_last_q, out_last_d;
    logic       frame_done_q, frame_done_d;
    logic       frame_ok_q, frame_ok_d;
    logic       len_err_q, len_err_d;
    logic [7:0] byte_count_q, byte_count_d;

    logic       accept;
    logic [7:0] desc;
    logic [7:0] lfsr_next;

    // Output stage frees up whenever it is empty or being drained this cycle.
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign desc      = in_data ^ lfsr_q;
    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : 8'h00);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        acc_d        = acc_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        len_err_d    = len_err_q;
        byte_count_d = byte_count_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = desc;
            out_last_d  = in_last;
            lfsr_d      = lfsr_next;

            case (state_q)
                IDLE: begin
                    if (in_last) begin
                        // Single-byte frame: checksum over an empty payload is zero.
                        frame_done_d = 1'b1;
                        frame_ok_d   = (desc == 8'h00);
                        len_err_d    = 1'b0;
                        byte_count_d = 8'd1;
                        lfsr_d       = SEED;
                        acc_d        = 8'h00;
                        count_d      = 8'h00;
                        state_d      = IDLE;
                    end else begin
                        acc_d   = desc;
                        count_d = 8'd1;
                        state_d = BODY;
                    end
                end
                BODY: begin
                    if (in_last) begin
                        frame_done_d = 1'b1;
                        frame_ok_d   = (acc_q == desc);
                        len_err_d    = 1'b0;
                        byte_count_d = count_q + 8'd1;
                        lfsr_d       = SEED;
                        acc_d        = 8'h00;
                        count_d      = 8'h00;
                        state_d      = IDLE;
                    end else if (count_q == LAST_IDX) begin
                        // Length abort: close the frame on this byte.
                        out_last_d   = 1'b1;
                        frame_done_d = 1'b1;
                        frame_ok_d   = 1'b0;
                        len_err_d    = 1'b1;
                        byte_count_d = MAX_LEN_B;
                        lfsr_d       = SEED;
                        acc_d        = 8'h00;
                        count_d      = 8'h00;
                        state_d      = IDLE;
                    end else begin
                        acc_d   = acc_q ^ desc;
                        count_d = count_q + 8'd1;
                        state_d = BODY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED;
            acc_q        <= 8'h00;
            count_q      <= 8'h00;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            len_err_q    <= 1'b0;
            byte_count_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            len_err_q    <= len_err_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign len_err    = len_err_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_xor_frame_descrambler.sv
// Scoreboard bench for xor_frame_descrambler: frame-level reference model feeds
// expectation queues; a negedge monitor pops and compares.
module tb_xor_frame_descrambler;

    localparam logic [7:0] SEED    = 8'hFF;
    localparam logic [7:0] POLY    = 8'hB8;
    localparam int         MAX_LEN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_done;
    logic       frame_ok;
    logic       len_err;
    logic [7:0] byte_count;

    logic rand_ready  = 1'b0;
    logic rnd_ready   = 1'b1;
    logic ready_force = 1'b1;
    logic mon_en      = 1'b0;

    assign out_ready = rand_ready ? rnd_ready : ready_force;

    always #5 clk = ~clk;

    xor_frame_descrambler #(.SEED(SEED), .POLY(POLY), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .frame_done(frame_done), .frame_ok(frame_ok), .len_err(len_err), .byte_count(byte_count)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } out_t;

    typedef struct packed {
        logic       ok;
        logic       lerr;
        logic [7:0] cnt;
    } st_t;

    out_t exp_out[$];
    st_t  exp_st[$];

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Keystream byte for position n of a frame, stepping the LFSR rule from SEED.
    function automatic logic [7:0] key_at(input int n);
        logic [7:0] s;
        s = SEED;
        for (int k = 0; k < n; k++) s = (s >> 1) ^ (s[0] ? POLY : 8'h00);
        return s;
    endfunction

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: handshakes pop the byte queue, frame_done pops the status queue.
    logic stalled = 1'b0;
    out_t held;
    always @(negedge clk) begin
        out_t e;
        st_t  s;
        if (mon_en) begin
            if (stalled) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'({out_data, out_last}), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_out: got %0h with nothing expected", out_data);
                end else begin
                    e = exp_out.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
            end
            if (frame_done) begin
                check("done_with_last", 32'({out_valid, out_last}), 32'd3);
                if (exp_st.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done: got frame_done with nothing expected");
                end else begin
                    s = exp_st.pop_front();
                    check("frame_ok", 32'(frame_ok), 32'(s.ok));
                    check("len_err", 32'(len_err), 32'(s.lerr));
                    check("byte_count", 32'(byte_count), 32'(s.cnt));
                end
            end
            stalled = out_valid && !out_ready && !rst;
            held    = '{data: out_data, last: out_last};
        end
    end

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_frame_ok"}, 32'(frame_ok), 32'd0);
        check({tag, "_len_err"}, 32'(len_err), 32'd0);
        check({tag, "_byte_count"}, 32'(byte_count), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int  guard;
        bit  rdy;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 200);
        if (!rdy) begin
            total++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", guard);
        end
        in_valid = 1'b0;
    endtask

    // Reference model for a whole frame of scrambled bytes, then drive it.
    task automatic do_frame(input logic [7:0] raw[$], input bit has_last,
                            input int gap_max, input int stall);
        int         n;
        logic [7:0] p[$];
        logic [7:0] xs;
        bit         lst;
        n  = raw.size();
        xs = 8'h00;
        for (int i = 0; i < n; i++) begin
            p.push_back(raw[i] ^ key_at(i));
            lst = has_last ? (i == n - 1) : (i == n - 1 && n == MAX_LEN);
            exp_out.push_back('{data: p[i], last: lst});
            if (i < n - 1) xs ^= p[i];
        end
        if (has_last)
            exp_st.push_back('{ok: (xs == p[n-1]), lerr: 1'b0, cnt: 8'(n)});
        else if (n == MAX_LEN)
            exp_st.push_back('{ok: 1'b0, lerr: 1'b1, cnt: 8'(MAX_LEN)});

        for (int i = 0; i < n; i++) begin
            send_byte(raw[i], has_last && (i == n - 1));
            if (i == 0 && stall > 0 && n > 1) begin
                ready_force = 1'b0;
                in_valid = 1'b1;
                in_data  = raw[1];
                in_last  = has_last && (n == 2);
                for (int k = 0; k < stall; k++) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                    check("bp_hold", 32'(out_data), 32'(p[0]));
                    @(posedge clk);
                    #1;
                end
                ready_force = 1'b1;
            end
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk);
            if (gap_max > 0) #1;
        end
    endtask

    initial begin
        logic [7:0] raw[$];
        logic [7:0] pl[$];
        logic [7:0] xs;
        int         len, kind, guard;

        repeat (3) @(posedge clk);
        check_reset_state("reset");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        raw = '{8'hED, 8'hF3, 8'hFD};
        do_frame(raw, 1'b1, 0, 0);
        raw = '{8'hED, 8'hF3, 8'hFC};
        do_frame(raw, 1'b1, 0, 0);
        raw = '{8'hED, 8'hF3, 8'hFD};
        do_frame(raw, 1'b1, 0, 0);
        raw = '{8'hFF};
        do_frame(raw, 1'b1, 0, 0);
        raw = '{8'hFE};
        do_frame(raw, 1'b1, 0, 0);
        raw = '{8'hED, 8'hF3, 8'hFD};
        do_frame(raw, 1'b1, 0, 3);
        raw = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_frame(raw, 1'b0, 0, 0);
        raw = '{8'hED, 8'hF3, 8'hFD};
        do_frame(raw, 1'b1, 0, 0);

        // Reset one cycle after the first byte of a frame.
        raw = '{8'hED};
        do_frame(raw, 1'b0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        raw = '{8'hED, 8'hF3, 8'hFD};
        do_frame(raw, 1'b1, 0, 0);

        rand_ready = 1'b1;
        for (int f = 0; f < 150; f++) begin
            len  = $urandom_range(1, MAX_LEN);
            kind = $urandom_range(0, 2);
            pl.delete();
            raw.delete();
            xs = 8'h00;
            if (kind == 2) len = MAX_LEN;
            for (int i = 0; i < len; i++) begin
                pl.push_back(8'($urandom));
                if (i < len - 1) xs ^= pl[i];
            end
            if (kind == 0) pl[len-1] = xs;
            for (int i = 0; i < len; i++) raw.push_back(pl[i] ^ key_at(i));
            do_frame(raw, kind != 2, $urandom_range(0, 1), 0);
        end
        rand_ready = 1'b0;

        guard = 0;
        while ((exp_out.size() != 0 || exp_st.size() != 0) && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        check("drain_out_queue", 32'(exp_out.size()), 32'd0);
        check("drain_status_queue", 32'(exp_st.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
